// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU op codes, encoding constants and the
// decoded-control bundle carried by the decode slot.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] ALU_ADD   = 6'd0;
   localparam logic [OP_W-1:0] ALU_SUB   = 6'd1;
   localparam logic [OP_W-1:0] ALU_XOR   = 6'd2;
   localparam logic [OP_W-1:0] ALU_OR    = 6'd3;
   localparam logic [OP_W-1:0] ALU_AND   = 6'd4;
   localparam logic [OP_W-1:0] ALU_SLL   = 6'd5;
   localparam logic [OP_W-1:0] ALU_SRL   = 6'd6;
   localparam logic [OP_W-1:0] ALU_SRA   = 6'd7;
   localparam logic [OP_W-1:0] ALU_SLT   = 6'd8;
   localparam logic [OP_W-1:0] ALU_SLTU  = 6'd9;
   localparam logic [OP_W-1:0] ALU_ADDI  = 6'd10;
   localparam logic [OP_W-1:0] ALU_XORI  = 6'd11;
   localparam logic [OP_W-1:0] ALU_ORI   = 6'd12;
   localparam logic [OP_W-1:0] ALU_ANDI  = 6'd13;
   localparam logic [OP_W-1:0] ALU_SLLI  = 6'd14;
   localparam logic [OP_W-1:0] ALU_SRLI  = 6'd15;
   localparam logic [OP_W-1:0] ALU_SRAI  = 6'd16;
   localparam logic [OP_W-1:0] ALU_SLTI  = 6'd17;
   localparam logic [OP_W-1:0] ALU_SLTIU = 6'd18;
   localparam logic [OP_W-1:0] ALU_AUIPC = 6'd19;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [OP_W-1:0] alu_op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            use_imm;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            branch_ne;
      logic            illegal;
   } dec_ctrl_t;

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
      return {{19{v[12]}}, v};
   endfunction

   // Only R-type, store and branch formats carry a real rs2 operand.
   function automatic logic opcode_reads_rs2(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface instr_decode_stage_if;
   import riscv_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] pc_in;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] alu_op;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   logic            use_imm;
   logic [XLEN-1:0] pc_out;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            branch;
   logic            branch_ne;
   logic            illegal;

   modport master (
      output in_valid, instr, pc_in, flush, out_ready,
      input  in_ready, out_valid, alu_op, rs1, rs2, rd, imm, use_imm, pc_out,
             reg_write, mem_read, mem_write, branch, branch_ne, illegal
   );

   modport slave (
      input  in_valid, instr, pc_in, flush, out_ready,
      output in_ready, out_valid, alu_op, rs1, rs2, rd, imm, use_imm, pc_out,
             reg_write, mem_read, mem_write, branch, branch_ne, illegal
   );

endinterface

// File: rtl/instr_decode_comb.sv
// Pure combinational RV32I subset decoder: instruction word to ALU controls,
// register indices and immediate.
module instr_decode_comb
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output dec_ctrl_t       ctrl,
   output logic            reads_rs2
);

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic [6:0] funct7_s;
   logic [4:0] rd_s;
   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   dec_ctrl_t  dec_s;
   logic       bad_s;

   assign opcode_s  = instr[6:0];
   assign rd_s      = instr[11:7];
   assign funct3_s  = instr[14:12];
   assign rs1_s     = instr[19:15];
   assign rs2_s     = instr[24:20];
   assign funct7_s  = instr[31:25];
   assign reads_rs2 = opcode_reads_rs2(opcode_s);

   // Per-format field extraction; bad_s flags any encoding outside the subset.
   always_comb begin
      dec_s = '0;
      bad_s = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            dec_s.rs1       = rs1_s;
            dec_s.rs2       = rs2_s;
            dec_s.rd        = rd_s;
            dec_s.reg_write = (rd_s != 5'd0);
            if (funct7_s == F7_BASE) begin
               case (funct3_s)
                  F3_ADD_SUB: dec_s.alu_op = ALU_ADD;
                  F3_SLL:     dec_s.alu_op = ALU_SLL;
                  F3_SLT:     dec_s.alu_op = ALU_SLT;
                  F3_SLTU:    dec_s.alu_op = ALU_SLTU;
                  F3_XOR:     dec_s.alu_op = ALU_XOR;
                  F3_SRL_SRA: dec_s.alu_op = ALU_SRL;
                  F3_OR:      dec_s.alu_op = ALU_OR;
                  F3_AND:     dec_s.alu_op = ALU_AND;
                  default:    bad_s = 1'b1;
               endcase
            end else if (funct7_s == F7_ALT) begin
               case (funct3_s)
                  F3_ADD_SUB: dec_s.alu_op = ALU_SUB;
                  F3_SRL_SRA: dec_s.alu_op = ALU_SRA;
                  default:    bad_s = 1'b1;
               endcase
            end else begin
               bad_s = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_s.rs1       = rs1_s;
            dec_s.rd        = rd_s;
            dec_s.use_imm   = 1'b1;
            dec_s.reg_write = (rd_s != 5'd0);
            dec_s.imm       = sext12(instr[31:20]);
            case (funct3_s)
               F3_ADD_SUB: dec_s.alu_op = ALU_ADDI;
               F3_SLT:     dec_s.alu_op = ALU_SLTI;
               F3_SLTU:    dec_s.alu_op = ALU_SLTIU;
               F3_XOR:     dec_s.alu_op = ALU_XORI;
               F3_OR:      dec_s.alu_op = ALU_ORI;
               F3_AND:     dec_s.alu_op = ALU_ANDI;
               F3_SLL: begin
                  dec_s.imm = {27'd0, rs2_s};
                  if (funct7_s == F7_BASE) begin
                     dec_s.alu_op = ALU_SLLI;
                  end else begin
                     bad_s = 1'b1;
                  end
               end
               F3_SRL_SRA: begin
                  dec_s.imm = {27'd0, rs2_s};
                  if (funct7_s == F7_BASE) begin
                     dec_s.alu_op = ALU_SRLI;
                  end else if (funct7_s == F7_ALT) begin
                     dec_s.alu_op = ALU_SRAI;
                  end else begin
                     bad_s = 1'b1;
                  end
               end
               default: bad_s = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_s.alu_op    = ALU_ADDI;
            dec_s.rd        = rd_s;
            dec_s.use_imm   = 1'b1;
            dec_s.reg_write = (rd_s != 5'd0);
            dec_s.imm       = {instr[31:12], 12'd0};
         end
         OPC_AUIPC: begin
            // The execute ALU applies the 12-bit shift for AUIPC itself.
            dec_s.alu_op    = ALU_AUIPC;
            dec_s.rd        = rd_s;
            dec_s.use_imm   = 1'b1;
            dec_s.reg_write = (rd_s != 5'd0);
            dec_s.imm       = {12'd0, instr[31:12]};
         end
         OPC_LOAD: begin
            dec_s.alu_op    = ALU_ADDI;
            dec_s.rs1       = rs1_s;
            dec_s.rd        = rd_s;
            dec_s.use_imm   = 1'b1;
            dec_s.imm       = sext12(instr[31:20]);
            dec_s.mem_read  = 1'b1;
            dec_s.reg_write = (rd_s != 5'd0);
            bad_s           = (funct3_s != F3_LW);
         end
         OPC_STORE: begin
            dec_s.alu_op    = ALU_ADDI;
            dec_s.rs1       = rs1_s;
            dec_s.rs2       = rs2_s;
            dec_s.use_imm   = 1'b1;
            dec_s.imm       = sext12({funct7_s, rd_s});
            dec_s.mem_write = 1'b1;
            bad_s           = (funct3_s != F3_SW);
         end
         OPC_BRANCH: begin
            dec_s.alu_op    = ALU_SUB;
            dec_s.rs1       = rs1_s;
            dec_s.rs2       = rs2_s;
            dec_s.imm       = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            dec_s.branch    = (funct3_s == F3_BEQ);
            dec_s.branch_ne = (funct3_s == F3_BNE);
            bad_s           = (funct3_s != F3_BEQ) && (funct3_s != F3_BNE);
         end
         default: bad_s = 1'b1;
      endcase
   end

   // Illegal encodings collapse to an all-zero bundle with only illegal set.
   always_comb begin
      ctrl = dec_s;
      if (bad_s) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
      end else begin
         ctrl = dec_s;
      end
   end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: one registered decode slot with valid/ready on both
// sides, a one-bubble load-use interlock and a branch flush.
module instr_decode_stage
   import riscv_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   instr_decode_stage_if.slave bus
);

   dec_ctrl_t       dec_s;
   logic            reads_rs2_s;
   dec_ctrl_t       slot_r;
   logic [XLEN-1:0] pc_r;
   logic            valid_r;
   logic            hazard_s;
   logic            ready_s;
   logic            load_s;

   instr_decode_comb u_decode (
      .instr     (bus.instr),
      .ctrl      (dec_s),
      .reads_rs2 (reads_rs2_s)
   );

   // rs1 is compared unconditionally; rs2 only for formats that read it.
   assign hazard_s = valid_r & slot_r.mem_read & (slot_r.rd != 5'd0) &
                     ((bus.instr[19:15] == slot_r.rd) |
                      (reads_rs2_s & (bus.instr[24:20] == slot_r.rd)));

   // Accept when the slot frees up this cycle, with no interlock or flush.
   always_comb begin
      ready_s = 1'b0;
      if (reset) begin
         ready_s = 1'b0;
      end else begin
         ready_s = (~valid_r | bus.out_ready) & ~hazard_s & ~bus.flush;
      end
   end

   assign load_s = bus.in_valid & ready_s;

   // Decode slot: flush wins, then load, then drain; otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         slot_r  <= '0;
         pc_r    <= '0;
      end else if (bus.flush) begin
         valid_r <= 1'b0;
      end else if (load_s) begin
         valid_r <= 1'b1;
         slot_r  <= dec_s;
         pc_r    <= bus.pc_in;
      end else if (bus.out_ready) begin
         valid_r <= 1'b0;
      end
   end

   assign bus.in_ready  = ready_s;
   assign bus.out_valid = valid_r;
   assign bus.alu_op    = slot_r.alu_op;
   assign bus.rs1       = slot_r.rs1;
   assign bus.rs2       = slot_r.rs2;
   assign bus.rd        = slot_r.rd;
   assign bus.imm       = slot_r.imm;
   assign bus.use_imm   = slot_r.use_imm;
   assign bus.pc_out    = pc_r;
   assign bus.reg_write = slot_r.reg_write;
   assign bus.mem_read  = slot_r.mem_read;
   assign bus.mem_write = slot_r.mem_write;
   assign bus.branch    = slot_r.branch;
   assign bus.branch_ne = slot_r.branch_ne;
   assign bus.illegal   = slot_r.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed cases plus random
// instruction streams against a behavioural decode/slot model.
module tb_instr_decode_stage;

   typedef struct packed {
      logic        v;
      logic [5:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        use_imm;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        bne;
      logic        ill;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   bit   exp_rdy;
   exp_t mdl;
   exp_t nxt;

   instr_decode_stage_if bus();

   instr_decode_stage dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [31:0] sx(input int val, input int bits);
      if (val >= (1 << (bits - 1))) return 32'(val - (1 << bits));
      else return 32'(val);
   endfunction

   // Reference decode: table lookups on funct3 plus explicit immediate arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      logic [5:0] r_tbl [8];
      logic [5:0] i_tbl [8];
      exp_t e;
      bit ok;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      r_tbl = '{6'd0, 6'd5, 6'd8, 6'd9, 6'd2, 6'd6, 6'd3, 6'd4};
      i_tbl = '{6'd10, 6'd14, 6'd17, 6'd18, 6'd11, 6'd15, 6'd12, 6'd13};
      opc = i[6:0];
      f3  = i[14:12];
      f7  = i[31:25];
      e = '0;
      ok = 1'b1;
      if (opc == 7'h33) begin
         e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.rw = (i[11:7] != 5'd0);
         if (f7 == 7'h00) e.op = r_tbl[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) e.op = 6'd1;
         else if (f7 == 7'h20 && f3 == 3'd5) e.op = 6'd7;
         else ok = 1'b0;
      end else if (opc == 7'h13) begin
         e.rs1 = i[19:15]; e.rd = i[11:7]; e.use_imm = 1'b1; e.rw = (i[11:7] != 5'd0);
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.imm = 32'(i[24:20]);
            if (f7 == 7'h00) e.op = i_tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = 6'd16;
            else ok = 1'b0;
         end else begin
            e.imm = sx(int'(i[31:20]), 12);
            e.op  = i_tbl[f3];
         end
      end else if (opc == 7'h37) begin
         e.op = 6'd10; e.rd = i[11:7]; e.use_imm = 1'b1; e.rw = (i[11:7] != 5'd0);
         e.imm = i & 32'hFFFF_F000;
      end else if (opc == 7'h17) begin
         e.op = 6'd19; e.rd = i[11:7]; e.use_imm = 1'b1; e.rw = (i[11:7] != 5'd0);
         e.imm = i >> 12;
      end else if (opc == 7'h03) begin
         ok = (f3 == 3'd2);
         e.op = 6'd10; e.rs1 = i[19:15]; e.rd = i[11:7]; e.use_imm = 1'b1;
         e.mr = 1'b1; e.rw = (i[11:7] != 5'd0); e.imm = sx(int'(i[31:20]), 12);
      end else if (opc == 7'h23) begin
         ok = (f3 == 3'd2);
         e.op = 6'd10; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.use_imm = 1'b1; e.mw = 1'b1;
         e.imm = sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
      end else if (opc == 7'h63) begin
         ok = (f3 < 3'd2);
         e.op = 6'd1; e.rs1 = i[19:15]; e.rs2 = i[24:20];
         e.br = (f3 == 3'd0); e.bne = (f3 == 3'd1);
         e.imm = sx(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13);
      end else begin
         ok = 1'b0;
      end
      if (!ok) begin
         e = '0;
         e.ill = 1'b1;
      end
      e.v  = 1'b1;
      e.pc = pc;
      return e;
   endfunction

   function automatic bit model_hazard(input exp_t m, input logic [31:0] i);
      bit r2;
      r2 = (i[6:0] == 7'h33) || (i[6:0] == 7'h23) || (i[6:0] == 7'h63);
      return m.v && m.mr && (m.rd != 5'd0) &&
             ((i[19:15] == m.rd) || (r2 && (i[24:20] == m.rd)));
   endfunction

   // Drive one cycle of inputs and work out in_ready and the next slot state.
   task automatic drive_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic fl, input logic ordy);
      @(negedge clock);
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.pc_in     = pc;
      bus.flush     = fl;
      bus.out_ready = ordy;
      #1;
      exp_rdy = (!mdl.v || ordy) && !model_hazard(mdl, ins) && !fl;
      nxt = mdl;
      if (fl) nxt.v = 1'b0;
      else if (v && exp_rdy) nxt = ref_decode(ins, pc);
      else if (ordy) nxt.v = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic tick();
      @(posedge clock);
      mdl = nxt;
      #1;
   endtask

   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
      drive_in(v, ins, pc, fl, ordy);
      tick();
   endtask

   function automatic logic [6:0] pick_f7();
      int r;
      r = $urandom_range(0, 3);
      if (r < 2) return 7'h00;
      else if (r == 2) return 7'h20;
      else return 7'($urandom);
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] i;
      int k;
      i = $urandom;
      k = $urandom_range(0, 9);
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
      case (k)
         0, 9: begin i[6:0] = 7'h33; i[31:25] = pick_f7(); end
         1: begin i[6:0] = 7'h13; if (i[13:12] == 2'b01) i[31:25] = pick_f7(); end
         2, 8: begin i[6:0] = 7'h03; if ($urandom_range(0, 7) != 0) i[14:12] = 3'd2; end
         3: begin i[6:0] = 7'h23; if ($urandom_range(0, 7) != 0) i[14:12] = 3'd2; end
         4: begin i[6:0] = 7'h63; if ($urandom_range(0, 7) != 0) i[14:12] = 3'($urandom_range(0, 1)); end
         5: i[6:0] = 7'h37;
         6: i[6:0] = 7'h17;
         default: i = i;
      endcase
      return i;
   endfunction

   // Single compare process: slot outputs after each edge, in_ready mid-cycle.
   always begin
      @(posedge clock);
      #1;
      if (chk_en) begin
         chk("out_valid", 32'(bus.out_valid), 32'(mdl.v));
         if (mdl.v) begin
            chk("alu_op", 32'(bus.alu_op), 32'(mdl.op));
            chk("rs1", 32'(bus.rs1), 32'(mdl.rs1));
            chk("rs2", 32'(bus.rs2), 32'(mdl.rs2));
            chk("rd", 32'(bus.rd), 32'(mdl.rd));
            chk("imm", bus.imm, mdl.imm);
            chk("pc_out", bus.pc_out, mdl.pc);
            chk("use_imm", 32'(bus.use_imm), 32'(mdl.use_imm));
            chk("reg_write", 32'(bus.reg_write), 32'(mdl.rw));
            chk("mem_read", 32'(bus.mem_read), 32'(mdl.mr));
            chk("mem_write", 32'(bus.mem_write), 32'(mdl.mw));
            chk("branch", 32'(bus.branch), 32'(mdl.br));
            chk("branch_ne", 32'(bus.branch_ne), 32'(mdl.bne));
            chk("illegal", 32'(bus.illegal), 32'(mdl.ill));
         end
      end
      @(negedge clock);
      #2;
      if (chk_en) chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
   end

   initial begin
      logic [31:0] cur;
      logic [31:0] pc;
      bit v;
      bit fl;
      bit ordy;

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.instr = '0; bus.pc_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      mdl = '0; nxt = '0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
      chk("rst_imm", bus.imm, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // addi x1,x0,5
      step(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b1);
      chk("addi_valid", 32'(bus.out_valid), 32'd1);
      chk("addi_op", 32'(bus.alu_op), 32'd10);
      chk("addi_rd", 32'(bus.rd), 32'd1);
      chk("addi_rs1", 32'(bus.rs1), 32'd0);
      chk("addi_imm", bus.imm, 32'd5);
      chk("addi_use_imm", 32'(bus.use_imm), 32'd1);
      chk("addi_reg_write", 32'(bus.reg_write), 32'd1);

      // sub x3,x1,x2
      step(1'b1, 32'h4020_81B3, 32'h0000_0104, 1'b0, 1'b1);
      chk("sub_op", 32'(bus.alu_op), 32'd1);
      chk("sub_rs1", 32'(bus.rs1), 32'd1);
      chk("sub_rs2", 32'(bus.rs2), 32'd2);
      chk("sub_rd", 32'(bus.rd), 32'd3);
      chk("sub_use_imm", 32'(bus.use_imm), 32'd0);

      // auipc x5,0x12345
      step(1'b1, 32'h1234_5297, 32'h0000_0108, 1'b0, 1'b1);
      chk("auipc_op", 32'(bus.alu_op), 32'd19);
      chk("auipc_imm", bus.imm, 32'h0001_2345);

      // lw x6,8(x1) then add x7,x6,x1: one bubble
      step(1'b1, 32'h0080_A303, 32'h0000_010C, 1'b0, 1'b1);
      chk("lw_mem_read", 32'(bus.mem_read), 32'd1);
      chk("lw_imm", bus.imm, 32'd8);
      drive_in(1'b1, 32'h0013_03B3, 32'h0000_0110, 1'b0, 1'b1);
      chk("lu_stall_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("lu_bubble", 32'(bus.out_valid), 32'd0);
      drive_in(1'b1, 32'h0013_03B3, 32'h0000_0110, 1'b0, 1'b1);
      chk("lu_resume_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("lu_add_valid", 32'(bus.out_valid), 32'd1);
      chk("lu_add_rd", 32'(bus.rd), 32'd7);
      chk("lu_add_pc", bus.pc_out, 32'h0000_0110);

      // execute stalls three cycles with xor x8,x1,x2 waiting
      for (int n = 0; n < 3; n++) begin
         drive_in(1'b1, 32'h0020_C433, 32'h0000_0114, 1'b0, 1'b0);
         chk("stall_ready", 32'(bus.in_ready), 32'd0);
         tick();
         chk("stall_rd_held", 32'(bus.rd), 32'd7);
      end
      drive_in(1'b1, 32'h0020_C433, 32'h0000_0114, 1'b0, 1'b1);
      chk("release_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("xor_op", 32'(bus.alu_op), 32'd2);

      // flush with slot full and or x9,x1,x2 offered
      drive_in(1'b1, 32'h0020_E4B3, 32'h0000_0118, 1'b1, 1'b0);
      chk("flush_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      step(1'b1, 32'h0020_E4B3, 32'h0000_0118, 1'b0, 1'b1);
      chk("after_flush_op", 32'(bus.alu_op), 32'd3);
      chk("after_flush_rd", 32'(bus.rd), 32'd9);

      // all-ones word is illegal but still occupies the slot
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_011C, 1'b0, 1'b1);
      chk("ill_valid", 32'(bus.out_valid), 32'd1);
      chk("ill_flag", 32'(bus.illegal), 32'd1);
      chk("ill_reg_write", 32'(bus.reg_write), 32'd0);
      chk("ill_op", 32'(bus.alu_op), 32'd0);

      // random stream; a stalled fetch usually keeps offering the same word
      cur = gen_instr();
      pc  = 32'h0000_1000;
      for (int n = 0; n < 2500; n++) begin
         v    = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 19) == 0);
         ordy = ($urandom_range(0, 9) < 7);
         drive_in(v, cur, pc, fl, ordy);
         if (v && exp_rdy) begin
            cur = gen_instr();
            pc  = pc + 32'd4;
         end else if ($urandom_range(0, 4) == 0) begin
            cur = gen_instr();
         end
         tick();
      end

      // asynchronous reset with a valid, stalled slot
      step(1'b1, 32'h0050_0093, 32'h0000_0ABC, 1'b0, 1'b0);
      @(negedge clock);
      chk_en = 1'b0;
      bus.in_valid = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_alu_op", 32'(bus.alu_op), 32'd0);
      chk("arst_rd", 32'(bus.rd), 32'd0);
      chk("arst_imm", bus.imm, 32'd0);
      chk("arst_use_imm", 32'(bus.use_imm), 32'd0);
      chk("arst_pc_out", bus.pc_out, 32'd0);
      chk("arst_reg_write", 32'(bus.reg_write), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
      mdl = '0;
      nxt = '0;
      @(negedge clock);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("arst_release_ready", 32'(bus.in_ready), 32'd1);

      for (int n = 0; n < 300; n++) begin
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         cur  = gen_instr();
         drive_in(v, cur, pc, 1'b0, ordy);
         if (v && exp_rdy) pc = pc + 32'd4;
         tick();
      end

      chk_en = 1'b0;
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
